// File: rtl/y86_mem_pkg.sv
// Shared types for the Y86 data-memory request port: size codes, clear/run
// states and the response pipeline entry.
package y86_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_W = 2'd1,
    SZ_L = 2'd2,
    SZ_Q = 2'd3
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int MAX_RD_LAT = 4;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [63:0] rdata;
  } rsp_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/dmem_req_port_if.sv
// Request/response bundle between the memory stage (master) and the data
// memory (slave).
interface dmem_req_port_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_error;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, init_done
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, init_done
  );
endinterface

// File: rtl/dmem_rsp_pipe.sv
// RD_LAT-deep shift register carrying {valid, error, rdata} from accept to
// response; idle slots hold zeros so the outputs read 0 when not valid.
module dmem_rsp_pipe
  import y86_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_error,
  input  logic [63:0] in_rdata,
  output logic        out_valid,
  output logic        out_error,
  output logic [63:0] out_rdata
);
  rsp_t stage_q [RD_LAT];
  rsp_t stage_d [RD_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi] = '{valid: in_valid,
                               error: in_valid & in_error,
                               rdata: in_valid ? in_rdata : 64'd0};
      end else begin : g_tail
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (rst) stage_q[i] <= '0;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign out_valid = stage_q[RD_LAT-1].valid;
  assign out_error = stage_q[RD_LAT-1].error;
  assign out_rdata = stage_q[RD_LAT-1].rdata;

endmodule

// File: rtl/dmem_req_port.sv
// Byte-addressed Y86 data memory: zero-fill after reset, then 1/2/4/8-byte
// little-endian accesses with range/alignment checking and pipelined responses.
module dmem_req_port
  import y86_mem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int RD_LAT      = 1,
  parameter int ALIGN_CHK   = 0
) (
  input  logic            clk,
  input  logic            rst,
  dmem_req_port_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH_BYTES - 8);

  logic [7:0]       mem_q [DEPTH_BYTES];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;

  logic             accept;
  logic             range_err, align_err, acc_error;
  logic [3:0]       n_bytes;
  logic [ADDR_W:0]  end_addr;
  logic [IDX_W-1:0] base_idx;
  logic [7:0]       lane_en;
  logic [63:0]      rd_data;
  logic [63:0]      pipe_in_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    bus.req_ready = 1'b0;
    bus.init_done = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + IDX_W'(8);
        if (clr_ptr_q == LAST_PTR) state_d = RUN;
      end
      RUN: begin
        bus.req_ready = 1'b1;
        bus.init_done = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Range check is one bit wider than the address so top-of-space requests
  // cannot wrap back into the array.
  assign n_bytes   = size_bytes(bus.req_size);
  assign end_addr  = {1'b0, bus.req_addr} + (ADDR_W+1)'(n_bytes);
  assign range_err = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
  assign align_err = (ALIGN_CHK != 0) &&
                     ((bus.req_addr[2:0] & (n_bytes[2:0] - 3'd1)) != 3'd0);
  assign acc_error = range_err | align_err;
  assign accept    = bus.req_valid && (state_q == RUN) && !rst;
  assign base_idx  = bus.req_addr[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_en[gi] = (4'(gi) < n_bytes);
      assign rd_data[8*gi +: 8] = lane_en[gi] ? mem_q[base_idx + IDX_W'(gi)] : 8'h00;
    end
  endgenerate

  assign pipe_in_rdata = (!bus.req_write && !acc_error) ? rd_data : 64'd0;

  always_ff @(posedge clk) begin
    if (state_q == CLEAR && !rst) begin
      for (int k = 0; k < 8; k++) mem_q[clr_ptr_q + IDX_W'(k)] <= 8'h00;
    end else if (accept && bus.req_write && !acc_error) begin
      for (int k = 0; k < 8; k++) begin
        if (lane_en[k]) mem_q[base_idx + IDX_W'(k)] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  dmem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_error  (acc_error),
    .in_rdata  (pipe_in_rdata),
    .out_valid (bus.rsp_valid),
    .out_error (bus.rsp_error),
    .out_rdata (bus.rsp_rdata)
  );

endmodule
